// File: rtl/bus_transfer_controller_pkg.sv
// Shared types for the bus transfer controller: operation codes, FSM state
// encoding and a few small helpers used by the interface and the RTL.
package bus_xfer_pkg;

    typedef enum logic [1:0] {
        OP_MOV  = 2'b00,
        OP_LDI  = 2'b01,
        OP_RD   = 2'b10,
        OP_RSVD = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_DRIVE   = 2'b01,
        ST_WRITE   = 2'b10,
        ST_RELEASE = 2'b11
    } state_t;

    localparam logic [15:0] XFER_COUNT_MAX = 16'hFFFF;

    // Select width; never zero so a single-register build still elaborates.
    function automatic int sel_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic idx_in_range(int unsigned idx, int unsigned n);
        return idx < n;
    endfunction

endpackage

// File: rtl/bus_transfer_controller_if.sv
// Request/status bundle of the bus transfer controller.
//
// Handshake: a request (Op/Src/Dst/Imm) is accepted at the rising edge where
// Start is high and State is ST_IDLE; Start in any other state is dropped,
// not queued. Busy is high from the cycle after acceptance through the Done
// cycle. Done is a one-cycle pulse; Err pulses with it for rejected requests.
interface bus_xfer_if
    import bus_xfer_pkg::*;
#(
    parameter int BitWidth = 8,
    parameter int NumRegs  = 4
);
    localparam int SelW = sel_width(NumRegs);

    logic                Start;
    logic [1:0]          Op;
    logic [SelW-1:0]     Src;
    logic [SelW-1:0]     Dst;
    logic [BitWidth-1:0] Imm;

    logic [NumRegs-1:0]  OE_n;
    logic [NumRegs-1:0]  EN_n;
    logic                Busy;
    logic                Done;
    logic                Err;
    logic [BitWidth-1:0] Data;
    logic [15:0]         XferCount;
    state_t              State;   // FSM state, exposed for observation

    modport slave (
        input  Start, Op, Src, Dst, Imm,
        output OE_n, EN_n, Busy, Done, Err, Data, XferCount, State
    );

    modport master (
        output Start, Op, Src, Dst, Imm,
        input  OE_n, EN_n, Busy, Done, Err, Data, XferCount, State
    );

endinterface

// File: rtl/bus_transfer_controller_sel_decoder.sv
// Index plus enable to active-low one-hot select. Out-of-range indices or a
// low enable give all ones, so at most one output bit is ever low.
module sel_decoder_n #(
    parameter int N    = 4,
    parameter int SelW = 2
) (
    input  logic [SelW-1:0] idx_i,
    input  logic            en_i,
    output logic [N-1:0]    sel_n_o
);

    // Pure decode of the registered index/enable from the controller.
    always_comb begin
        sel_n_o = '1;
        for (int i = 0; i < N; i++) begin
            if (en_i && (idx_i == SelW'(i))) begin
                sel_n_o[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_transfer_controller.sv
// Bus transfer controller: sequences MOV / LDI / RD transfers over a shared
// tri-state bus as IDLE -> DRIVE -> WRITE -> RELEASE. The RELEASE cycle is a
// turnaround with every strobe and the Bus drive off before the next request.
module bus_transfer_controller
    import bus_xfer_pkg::*;
#(
    parameter int BitWidth = 8,
    parameter int NumRegs  = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    inout  wire  [BitWidth-1:0] Bus,
    bus_xfer_if.slave           bus_if
);

    localparam int SelW = sel_width(NumRegs);

    state_t              state_q;
    op_t                 op_q;
    logic [SelW-1:0]     src_q;
    logic [SelW-1:0]     dst_q;
    logic [BitWidth-1:0] imm_q;
    logic                oe_en_q;   // source register output enable
    logic                ld_en_q;   // destination register load enable
    logic                drv_q;     // controller drives Imm onto Bus
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [BitWidth-1:0] data_q;
    logic [15:0]         count_q;

    op_t                 req_op_d;
    logic                req_legal_d;
    logic [NumRegs-1:0]  oe_n;
    logic [NumRegs-1:0]  en_n;

    assign req_op_d = op_t'(bus_if.Op);

    // Classify the incoming request; illegal ones never touch the bus.
    always_comb begin
        req_legal_d = 1'b1;
        if (req_op_d == OP_RSVD) begin
            req_legal_d = 1'b0;
        end
        if ((req_op_d == OP_MOV) && (bus_if.Src == bus_if.Dst)) begin
            req_legal_d = 1'b0;
        end
        if (!idx_in_range(32'(bus_if.Src), NumRegs) ||
            !idx_in_range(32'(bus_if.Dst), NumRegs)) begin
            req_legal_d = 1'b0;
        end
    end

    // Transfer sequencer; every output-facing control bit is a register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MOV;
            src_q   <= '0;
            dst_q   <= '0;
            imm_q   <= '0;
            oe_en_q <= 1'b0;
            ld_en_q <= 1'b0;
            drv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus_if.Start) begin
                        op_q   <= req_op_d;
                        src_q  <= bus_if.Src;
                        dst_q  <= bus_if.Dst;
                        imm_q  <= bus_if.Imm;
                        busy_q <= 1'b1;
                        if (req_legal_d) begin
                            state_q <= ST_DRIVE;
                            oe_en_q <= (req_op_d != OP_LDI);
                            drv_q   <= (req_op_d == OP_LDI);
                        end else begin
                            state_q <= ST_RELEASE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
                    end
                end
                ST_DRIVE: begin
                    // Source keeps driving; destination load opens for one cycle.
                    state_q <= ST_WRITE;
                    ld_en_q <= (op_q != OP_RD);
                end
                ST_WRITE: begin
                    // Destination loads at this edge; drop every driver for turnaround.
                    state_q <= ST_RELEASE;
                    oe_en_q <= 1'b0;
                    ld_en_q <= 1'b0;
                    drv_q   <= 1'b0;
                    done_q  <= 1'b1;
                    if (op_q == OP_RD) begin
                        data_q <= Bus;
                    end
                    if (count_q != XFER_COUNT_MAX) begin
                        count_q <= count_q + 16'd1;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    sel_decoder_n #(.N(NumRegs), .SelW(SelW)) u_oe_dec (
        .idx_i   (src_q),
        .en_i    (oe_en_q),
        .sel_n_o (oe_n)
    );

    sel_decoder_n #(.N(NumRegs), .SelW(SelW)) u_en_dec (
        .idx_i   (dst_q),
        .en_i    (ld_en_q),
        .sel_n_o (en_n)
    );

    assign Bus              = drv_q ? imm_q : {BitWidth{1'bz}};
    assign bus_if.OE_n      = oe_n;
    assign bus_if.EN_n      = en_n;
    assign bus_if.Busy      = busy_q;
    assign bus_if.Done      = done_q;
    assign bus_if.Err       = err_q;
    assign bus_if.Data      = data_q;
    assign bus_if.XferCount = count_q;
    assign bus_if.State     = state_q;

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Bench for bus_transfer_controller: emulates a 4-entry register file on the
// shared bus, keeps a reference model of registers/Data/XferCount, and
// compares every Done against the expected queue.
module tb_bus_transfer_controller;
    import bus_xfer_pkg::*;

    localparam int W = 8;
    localparam int N = 4;
    localparam int SW = $clog2(N);

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wire [W-1:0] bus;
    bus_xfer_if #(.BitWidth(W), .NumRegs(N)) bif ();

    bus_transfer_controller #(.BitWidth(W), .NumRegs(N)) dut (
        .Clk    (clk),
        .Reset  (rst_n),
        .Bus    (bus),
        .bus_if (bif)
    );

    // ---------------- register file emulation ----------------
    logic [W-1:0]  emu_regs [N] = '{8'h00, 8'h11, 8'h22, 8'h33};
    logic          emu_drv;
    logic [SW-1:0] emu_idx;

    always_comb begin
        emu_drv = 1'b0;
        emu_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!bif.OE_n[i]) begin
                emu_drv = 1'b1;
                emu_idx = SW'(i);
            end
        end
    end

    assign bus = emu_drv ? emu_regs[emu_idx] : {W{1'bz}};

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!bif.EN_n[i]) emu_regs[i] <= bus;
        end
    end

    // ---------------- model and scoreboard ----------------
    logic [24:0]   exp_q[$];          // {Err, XferCount, Data}
    logic [W-1:0]  m_regs [N] = '{8'h00, 8'h11, 8'h22, 8'h33};
    logic [W-1:0]  m_data  = '0;
    logic [15:0]   m_count = '0;
    logic [1:0]    m_cur_op  = 2'b00;
    logic [W-1:0]  m_cur_imm = '0;
    int n_vec = 0;
    int n_err = 0;

    task automatic model_submit(input logic [1:0] op, input logic [SW-1:0] src,
                                input logic [SW-1:0] dst, input logic [W-1:0] imm,
                                output logic legal);
        legal = (op != 2'b11) && !((op == 2'b00) && (src == dst));
        m_cur_op  = op;
        m_cur_imm = imm;
        if (legal) begin
            case (op)
                2'b00:   m_regs[dst] = m_regs[src];
                2'b01:   m_regs[dst] = imm;
                default: m_data = m_regs[src];
            endcase
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
        end
        exp_q.push_back({~legal, m_count, m_data});
    endtask

    task automatic monitor();
        logic [24:0] exp_v;
        logic [24:0] got_v;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                n_vec++;
                if ($countones(~bif.OE_n) > 1) begin
                    n_err++; $display("FAIL oe_onehot: OE_n=%b, at most one low bit required", bif.OE_n);
                end
                n_vec++;
                if ($countones(~bif.EN_n) > 1) begin
                    n_err++; $display("FAIL en_onehot: EN_n=%b, at most one low bit required", bif.EN_n);
                end
                n_vec++;
                if (bif.Err && !bif.Done) begin
                    n_err++; $display("FAIL err_without_done: Err=1 Done=0, Err must coincide with Done");
                end
                if (bif.Done) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++; $display("FAIL unexpected_done: Done=1 with no outstanding request");
                    end else begin
                        exp_v = exp_q.pop_front();
                        got_v = {bif.Err, bif.XferCount, bif.Data};
                        if (got_v !== exp_v) begin
                            n_err++;
                            $display("FAIL done_result: got Err=%b Cnt=%h Data=%h, want Err=%b Cnt=%h Data=%h",
                                     got_v[24], got_v[23:8], got_v[7:0], exp_v[24], exp_v[23:8], exp_v[7:0]);
                        end
                    end
                end
                if (m_cur_op == 2'b01 && (bif.State == ST_DRIVE || bif.State == ST_WRITE)) begin
                    n_vec++;
                    if (bif.OE_n !== 4'b1111 || bus !== m_cur_imm) begin
                        n_err++;
                        $display("FAIL ldi_bus_owner: OE_n=%b Bus=%h, want OE_n=1111 Bus=%h", bif.OE_n, bus, m_cur_imm);
                    end
                end
            end
        end
    endtask

    // ---------------- driver ----------------
    // Returns at the falling edge of the first cycle after acceptance.
    task automatic start_req(input logic [1:0] op, input logic [SW-1:0] src,
                             input logic [SW-1:0] dst, input logic [W-1:0] imm);
        logic legal;
        @(negedge clk);
        bif.Start = 1'b1;
        bif.Op = op; bif.Src = src; bif.Dst = dst; bif.Imm = imm;
        model_submit(op, src, dst, imm, legal);
        @(posedge clk);
        @(negedge clk);
        bif.Start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_vec++; if (bif.OE_n !== 4'b1111) begin n_err++; $display("FAIL rst_oe: got %b want 1111", bif.OE_n); end
        n_vec++; if (bif.EN_n !== 4'b1111) begin n_err++; $display("FAIL rst_en: got %b want 1111", bif.EN_n); end
        n_vec++; if (bif.Busy !== 1'b0 || bif.Done !== 1'b0 || bif.Err !== 1'b0) begin
            n_err++; $display("FAIL rst_flags: Busy=%b Done=%b Err=%b want 000", bif.Busy, bif.Done, bif.Err);
        end
        n_vec++; if (bif.Data !== 8'h00 || bif.XferCount !== 16'h0000) begin
            n_err++; $display("FAIL rst_data_cnt: Data=%h Cnt=%h want 00/0000", bif.Data, bif.XferCount);
        end
        n_vec++; if (bif.State !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want IDLE", bif.State); end
        rst_n = 1'b1;
    endtask

    task automatic test_ldi();
        start_req(2'b01, 2'd0, 2'd1, 8'hA5);
        n_vec++; if (bif.State !== ST_DRIVE || bif.EN_n !== 4'b1111 || bif.Busy !== 1'b1) begin
            n_err++; $display("FAIL ldi_drive: State=%0d EN_n=%b Busy=%b want DRIVE 1111 1", bif.State, bif.EN_n, bif.Busy);
        end
        @(negedge clk);
        n_vec++; if (bif.EN_n !== 4'b1101 || bif.Done !== 1'b0) begin
            n_err++; $display("FAIL ldi_write: EN_n=%b Done=%b want 1101 0", bif.EN_n, bif.Done);
        end
        @(negedge clk);
        n_vec++; if (bif.Done !== 1'b1 || bif.EN_n !== 4'b1111) begin
            n_err++; $display("FAIL ldi_release: Done=%b EN_n=%b want 1 1111", bif.Done, bif.EN_n);
        end
        @(negedge clk);
        n_vec++; if (emu_regs[1] !== 8'hA5 || bif.XferCount !== 16'd1 || bif.Busy !== 1'b0) begin
            n_err++; $display("FAIL ldi_after: R1=%h Cnt=%0d Busy=%b want a5 1 0", emu_regs[1], bif.XferCount, bif.Busy);
        end
    endtask

    task automatic test_mov();
        start_req(2'b00, 2'd1, 2'd3, 8'h00);
        n_vec++; if (bif.OE_n !== 4'b1101 || bif.EN_n !== 4'b1111) begin
            n_err++; $display("FAIL mov_drive: OE_n=%b EN_n=%b want 1101 1111", bif.OE_n, bif.EN_n);
        end
        @(negedge clk);
        n_vec++; if (bif.OE_n !== 4'b1101 || bif.EN_n !== 4'b0111) begin
            n_err++; $display("FAIL mov_write: OE_n=%b EN_n=%b want 1101 0111", bif.OE_n, bif.EN_n);
        end
        @(negedge clk);
        n_vec++; if (bif.Done !== 1'b1 || bif.OE_n !== 4'b1111 || bif.EN_n !== 4'b1111) begin
            n_err++; $display("FAIL mov_release: Done=%b OE_n=%b EN_n=%b want 1 1111 1111", bif.Done, bif.OE_n, bif.EN_n);
        end
        n_vec++; if (emu_regs[3] !== 8'hA5 || bif.XferCount !== 16'd2) begin
            n_err++; $display("FAIL mov_after: R3=%h Cnt=%0d want a5 2", emu_regs[3], bif.XferCount);
        end
    endtask

    task automatic test_rd();
        start_req(2'b10, 2'd3, 2'd0, 8'h00);
        n_vec++; if (bif.OE_n !== 4'b0111 || bif.EN_n !== 4'b1111) begin
            n_err++; $display("FAIL rd_drive: OE_n=%b EN_n=%b want 0111 1111", bif.OE_n, bif.EN_n);
        end
        @(negedge clk);
        n_vec++; if (bif.OE_n !== 4'b0111 || bif.EN_n !== 4'b1111) begin
            n_err++; $display("FAIL rd_write: OE_n=%b EN_n=%b want 0111 1111", bif.OE_n, bif.EN_n);
        end
        @(negedge clk);
        n_vec++; if (bif.Done !== 1'b1 || bif.Data !== 8'hA5 || bif.EN_n !== 4'b1111) begin
            n_err++; $display("FAIL rd_release: Done=%b Data=%h EN_n=%b want 1 a5 1111", bif.Done, bif.Data, bif.EN_n);
        end
    endtask

    task automatic test_illegal();
        logic [5:0] reqs [2];
        reqs[0] = {2'b00, 2'd2, 2'd2};
        reqs[1] = {2'b11, 2'd0, 2'd1};
        for (int k = 0; k < 2; k++) begin
            start_req(reqs[k][5:4], reqs[k][3:2], reqs[k][1:0], 8'h3C);
            n_vec++;
            if (bif.Done !== 1'b1 || bif.Err !== 1'b1 || bif.State !== ST_RELEASE) begin
                n_err++; $display("FAIL illegal_%0d_flags: Done=%b Err=%b State=%0d want 1 1 RELEASE",
                                  k, bif.Done, bif.Err, bif.State);
            end
            n_vec++;
            if (bif.OE_n !== 4'b1111 || bif.EN_n !== 4'b1111) begin
                n_err++; $display("FAIL illegal_%0d_strobes: OE_n=%b EN_n=%b want 1111 1111", k, bif.OE_n, bif.EN_n);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic legal;
        m_cur_op = 2'b00;
        @(negedge clk);
        bif.Start = 1'b1; bif.Op = 2'b00; bif.Src = 2'd1; bif.Dst = 2'd0; bif.Imm = 8'h00;
        @(posedge clk);
        @(negedge clk);
        bif.Start = 1'b0;
        @(negedge clk);
        n_vec++; if (bif.EN_n !== 4'b1110) begin n_err++; $display("FAIL abort_write: EN_n=%b want 1110", bif.EN_n); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (bif.OE_n !== 4'b1111 || bif.EN_n !== 4'b1111 || bif.State !== ST_IDLE) begin
            n_err++; $display("FAIL abort_async: OE_n=%b EN_n=%b State=%0d want 1111 1111 IDLE", bif.OE_n, bif.EN_n, bif.State);
        end
        n_vec++; if (bif.Done !== 1'b0 || bif.Busy !== 1'b0 || bif.XferCount !== 16'd0) begin
            n_err++; $display("FAIL abort_flags: Done=%b Busy=%b Cnt=%0d want 0 0 0", bif.Done, bif.Busy, bif.XferCount);
        end
        m_count = '0;
        m_data  = '0;
        repeat (2) @(negedge clk);
        n_vec++; if (emu_regs[0] !== 8'h00) begin n_err++; $display("FAIL abort_dest: R0=%h want 00", emu_regs[0]); end
        // Release and request in the same cycle: the first rising edge must accept.
        rst_n = 1'b1;
        bif.Start = 1'b1; bif.Op = 2'b01; bif.Src = 2'd0; bif.Dst = 2'd2; bif.Imm = 8'h5A;
        model_submit(2'b01, 2'd0, 2'd2, 8'h5A, legal);
        @(posedge clk);
        @(negedge clk);
        bif.Start = 1'b0;
        n_vec++; if (bif.State !== ST_DRIVE) begin n_err++; $display("FAIL first_start: State=%0d want DRIVE", bif.State); end
        repeat (3) @(negedge clk);
        n_vec++; if (emu_regs[2] !== 8'h5A) begin n_err++; $display("FAIL post_reset_ldi: R2=%h want 5a", emu_regs[2]); end
    endtask

    task automatic test_back_to_back();
        int wait_cnt;
        logic legal;
        logic [1:0] op;
        logic [SW-1:0] src, dst;
        logic [W-1:0] imm;
        wait_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            op  = 2'($urandom_range(0, 3));
            src = SW'($urandom_range(0, N - 1));
            dst = SW'($urandom_range(0, N - 1));
            imm = W'($urandom_range(0, 255));
            bif.Start = 1'b1; bif.Op = op; bif.Src = src; bif.Dst = dst; bif.Imm = imm;
            if (wait_cnt == 0) begin
                model_submit(op, src, dst, imm, legal);
                wait_cnt = legal ? 3 : 1;
            end else begin
                wait_cnt--;
            end
        end
        @(negedge clk);
        bif.Start = 1'b0;
        for (int t = 0; t < 12 && exp_q.size() != 0; t++) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL b2b_drain: %0d requests still pending, want 0", exp_q.size());
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            n_vec++;
            if (emu_regs[i] !== m_regs[i]) begin
                n_err++; $display("FAIL b2b_reg%0d: got %h want %h", i, emu_regs[i], m_regs[i]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bif.Start = 1'b0; bif.Op = 2'b00; bif.Src = '0; bif.Dst = '0; bif.Imm = '0;
        fork
            monitor();
        join_none
        test_reset();
        test_ldi();
        test_mov();
        test_rd();
        test_illegal();
        test_reset_abort();
        test_back_to_back();
        repeat (2) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL leftover: %0d expected results never completed", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
